pipe_stage_reg: RTL

- Parametrised inter-stage pipeline register that replaces the per-stage hand-written registers (D/E/M/W).
- Carries a packed multi-lane data payload, destination register, write enable, the forwarding countdown T_new, PC, instruction word, delay-slot flag and exception code.
- Adds stall (hold), flush (bubble) and exception-request handling, plus exception-code merging and $0 write suppression.
- One instance sits between each pair of adjacent pipeline stages.

---
 rtl/pipe_stage_reg.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the D/E/M/W boundaries.
// Carries a multi-lane payload plus pipeline bookkeeping (destination, write
// enable, forwarding countdown, PC, instruction, delay-slot flag, exception
// code). It supports stall (hold), flush (bubble) and exception-request
// bubbles. Edge priority: req > flush > hold > capture.
// Every output comes straight from a flop, so there is no combinational path
// from any input to any output.
module pipe_stage_reg #(
    parameter int          N_LANES          = 4,
    parameter int          LANE_W           = 32,
    parameter int          TNEW_W           = 2,
    parameter bit          KEEP_PC_ON_FLUSH = 1'b1,
    parameter logic [31:0] REQ_PC           = 32'h0000_4180
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      flush,
    input  logic                      req,
    input  logic                      valid_in,
    input  logic                      we_in,
    input  logic [4:0]                a3_in,
    input  logic [TNEW_W-1:0]         t_new_in,
    input  logic [31:0]               pc_in,
    input  logic [31:0]               instr_in,
    input  logic                      bd_in,
    input  logic [4:0]                exc_in,
    input  logic [4:0]                exc_local,
    input  logic [N_LANES*LANE_W-1:0] data_in,
    output logic                      valid_out,
    output logic                      we_out,
    output logic [4:0]                a3_out,
    output logic [TNEW_W-1:0]         t_new_out,
    output logic [31:0]               pc_out,
    output logic [31:0]               instr_out,
    output logic                      bd_out,
    output logic [4:0]                exc_out,
    output logic [N_LANES*LANE_W-1:0] data_out
);

    localparam int DATA_W = N_LANES * LANE_W;

    logic              valid_q, valid_d;
    logic              we_q,    we_d;
    logic [4:0]        a3_q,    a3_d;
    logic [TNEW_W-1:0] t_new_q, t_new_d;
    logic [31:0]       pc_q,    pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              bd_q,    bd_d;
    logic [4:0]        exc_q,   exc_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // Values presented by a normal capture.
    logic              cap_we;
    logic [TNEW_W-1:0] cap_t_new;
    logic [4:0]        cap_exc;

    // Capture-path transforms: $0 write suppression, saturating countdown,
    // and exception merge where the earlier stage's code wins.
    always_comb begin
        cap_we    = we_in & valid_in & (a3_in != 5'd0);
        cap_t_new = (t_new_in != '0) ? (t_new_in - TNEW_W'(1)) : '0;
        if (!valid_in) begin
            cap_exc = 5'd0;
        end else if (exc_in != 5'd0) begin
            cap_exc = exc_in;
        end else begin
            cap_exc = exc_local;
        end
    end

    // Next-state selection: req bubble, flush bubble, hold, or capture.
    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        a3_d    = a3_q;
        t_new_d = t_new_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        bd_d    = bd_q;
        exc_d   = exc_q;
        data_d  = data_q;

        if (req) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            a3_d    = 5'd0;
            t_new_d = '0;
            instr_d = 32'd0;
            exc_d   = 5'd0;
            data_d  = '0;
            pc_d    = REQ_PC;
            bd_d    = 1'b0;
        end else if (flush) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            a3_d    = 5'd0;
            t_new_d = '0;
            instr_d = 32'd0;
            exc_d   = 5'd0;
            data_d  = '0;
            // Keeping PC/BD on the bubble lets CP0 compute EPC for the slot.
            pc_d    = KEEP_PC_ON_FLUSH ? pc_in : 32'd0;
            bd_d    = KEEP_PC_ON_FLUSH ? bd_in : 1'b0;
        end else if (en) begin
            valid_d = valid_in;
            we_d    = cap_we;
            a3_d    = a3_in;
            t_new_d = cap_t_new;
            pc_d    = pc_in;
            instr_d = instr_in;
            bd_d    = bd_in;
            exc_d   = cap_exc;
            data_d  = data_in;
        end
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            a3_q    <= 5'd0;
            t_new_q <= '0;
            pc_q    <= 32'd0;
            instr_q <= 32'd0;
            bd_q    <= 1'b0;
            exc_q   <= 5'd0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            a3_q    <= a3_d;
            t_new_q <= t_new_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            bd_q    <= bd_d;
            exc_q   <= exc_d;
            data_q  <= data_d;
        end
    end

    assign valid_out = valid_q;
    assign we_out    = we_q;
    assign a3_out    = a3_q;
    assign t_new_out = t_new_q;
    assign pc_out    = pc_q;
    assign instr_out = instr_q;
    assign bd_out    = bd_q;
    assign exc_out   = exc_q;
    assign data_out  = data_q;

endmodule
